pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/halt sequencer and hazard unit for a 5-stage pipeline.
// Produces PC/IF-ID enables, flush/bubble controls and cycle/stall statistics.
`default_nettype none

module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int SCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [1:0]        dbg_cmd,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  input  logic              halt_op,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_ena,
  output logic [2:0]        state,
  output logic              halted,
  output logic [31:0]       cycle_count,
  output logic [SCNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t          cur_state;
  logic [DW-1:0]   drain_cnt;
  logic            load_use;
  logic            active;
  logic            draining;
  logic            stall_evt;

  assign state = cur_state;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign active    = ena && ((cur_state == RUN) || (cur_state == STEP));
  assign draining  = ena && (cur_state == DRAIN);
  // A taken branch flushes the stalled instruction anyway, so it is not a stall.
  assign stall_evt = active && load_use && !ex_branch_taken;

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_ena    = 1'b0;
    if (active) begin
      pipe_ena = 1'b1;
      if (ex_branch_taken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end else if (draining) begin
      pipe_ena = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state   <= IDLE;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      stall_count <= '0;
    end else if (ena) begin
      if (pipe_ena) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (stall_evt && (stall_count != {SCNT_W{1'b1}})) begin
        stall_count <= stall_count + SCNT_W'(1);
      end
      case (cur_state)
        IDLE: begin
          if (dbg_cmd == CMD_RUN) begin
            cur_state <= RUN;
          end else if (dbg_cmd == CMD_STEP) begin
            cur_state <= STEP;
          end
        end
        RUN: begin
          // HALT beats a simultaneous stop so the pipeline always drains cleanly.
          if (halt_op && !ex_branch_taken) begin
            cur_state <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (dbg_cmd == CMD_STOP) begin
            cur_state <= IDLE;
          end
        end
        STEP: begin
          cur_state <= IDLE;
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            cur_state <= HALTED;
            halted    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: begin
          cur_state <= HALTED;
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenario bench for pipeline_ctrl with hand-computed expectations.
`default_nettype none

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  dbg_cmd;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        halt_op;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pipe_ena;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;
  int exp_cyc = 0;
  int exp_stall = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .SCNT_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dbg_cmd(dbg_cmd),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .halt_op(halt_op), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_ena(pipe_ena),
    .state(state), .halted(halted), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0; halt_op = 0;
  endtask

  task automatic test_reset();
    rst = 0; ena = 1; dbg_cmd = 2'b00; clear_hazards();
    #2;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", cycle_count); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stalls: got %0d expected 0", stall_count); end
    checks++; if ({pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush} !== 5'b00000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush}); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_run();
    dbg_cmd = 2'b01;
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL idle_pc_write: got %b expected 0", pc_write); end
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_entry: got %0d expected 1", state); end
    dbg_cmd = 2'b00;
    #1;
    checks++; if ({pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush} !== 5'b11100) begin
      errors++; $display("FAIL run_outputs: got %b expected 11100", {pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush}); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL run_cycles0: got %0d expected %0d", cycle_count, exp_cyc); end
    for (int i = 0; i < 2; i++) begin
      tick(); exp_cyc++;
      checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL run_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    #1;
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_ena} !== 5'b00011) begin
      errors++; $display("FAIL load_use_outputs: got %b expected 00011", {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_ena}); end
    tick(); exp_cyc++; exp_stall++;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL load_use_stalls: got %0d expected %0d", stall_count, exp_stall); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL load_use_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
    ex_rt = 0; id_rs = 0;
    #1;
    checks++; if ({pc_write, id_ex_flush} !== 2'b10) begin errors++; $display("FAIL r0_no_stall: got %b expected 10", {pc_write, id_ex_flush}); end
    tick(); exp_cyc++;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL r0_stalls: got %0d expected %0d", stall_count, exp_stall); end
    clear_hazards();
  endtask

  task automatic test_rt_hazard();
    ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_rs = 3; id_uses_rt = 1;
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rt_hazard: got %b expected 0", pc_write); end
    id_uses_rt = 0;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rt_unused: got %b expected 1", pc_write); end
    id_uses_rt = 1;
    tick(); exp_cyc++; exp_stall++;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL rt_stalls: got %0d expected %0d", stall_count, exp_stall); end
    clear_hazards();
  endtask

  task automatic test_branch_priority();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; ex_branch_taken = 1; halt_op = 1;
    #1;
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== 4'b1111) begin
      errors++; $display("FAIL branch_outputs: got %b expected 1111", {pc_write, if_id_write, if_id_flush, id_ex_flush}); end
    tick(); exp_cyc++;
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL branch_stalls: got %0d expected %0d", stall_count, exp_stall); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL branch_halt_ignored: got %0d expected 1", state); end
    clear_hazards();
  endtask

  task automatic test_ena_freeze();
    ena = 0; dbg_cmd = 2'b11; ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    #1;
    checks++; if ({pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush} !== 5'b00000) begin
      errors++; $display("FAIL ena_outputs: got %b expected 00000", {pc_write, if_id_write, pipe_ena, if_id_flush, id_ex_flush}); end
    repeat (4) tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ena_state: got %0d expected 1", state); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL ena_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
    checks++; if (stall_count !== 16'(exp_stall)) begin errors++; $display("FAIL ena_stalls: got %0d expected %0d", stall_count, exp_stall); end
    ena = 1; dbg_cmd = 2'b00; clear_hazards();
  endtask

  task automatic test_stop();
    dbg_cmd = 2'b11;
    tick(); exp_cyc++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL stop_state: got %0d expected 0", state); end
    dbg_cmd = 2'b00;
    tick();
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL stop_pipe_ena: got %b expected 0", pipe_ena); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL stop_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
  endtask

  task automatic test_step();
    dbg_cmd = 2'b10;
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL step_state: got %0d expected 2", state); end
    dbg_cmd = 2'b01;
    #1;
    checks++; if ({pipe_ena, pc_write} !== 2'b11) begin errors++; $display("FAIL step_outputs: got %b expected 11", {pipe_ena, pc_write}); end
    tick(); exp_cyc++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL step_return: got %0d expected 0", state); end
    dbg_cmd = 2'b00;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL step_idle_hold: got %0d expected 0", state); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL step_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
  endtask

  task automatic test_halt_drain();
    dbg_cmd = 2'b01;
    tick();
    dbg_cmd = 2'b11; halt_op = 1;
    tick(); exp_cyc++;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL halt_wins: got %0d expected 3", state); end
    halt_op = 0; dbg_cmd = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({state, pipe_ena, pc_write, if_id_write, halted} !== {3'd3, 4'b1000}) begin
        errors++; $display("FAIL drain_cycle%0d: got %b expected %b", i, {state, pipe_ena, pc_write, if_id_write, halted}, {3'd3, 4'b1000}); end
      tick(); exp_cyc++;
    end
    checks++; if ({state, halted} !== {3'd4, 1'b1}) begin errors++; $display("FAIL halted_entry: got %b expected 1001", {state, halted}); end
    repeat (3) tick();
    checks++; if ({state, pipe_ena} !== {3'd4, 1'b0}) begin errors++; $display("FAIL halted_hold: got %b expected 1000", {state, pipe_ena}); end
    checks++; if (cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL halted_cycles: got %0d expected %0d", cycle_count, exp_cyc); end
    dbg_cmd = 2'b00;
    #2; rst = 0; #1;
    checks++; if ({state, halted} !== {3'd0, 1'b0}) begin errors++; $display("FAIL halted_reset: got %b expected 0000", {state, halted}); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); rst = 1; dbg_cmd = 2'b01;
    tick();
    dbg_cmd = 2'b00; halt_op = 1;
    tick();
    halt_op = 0;
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL mid_drain_state: got %0d expected 3", state); end
    #2; rst = 0; #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_drain_reset_state: got %0d expected 0", state); end
    checks++; if ({cycle_count, stall_count} !== 48'd0) begin
      errors++; $display("FAIL mid_drain_reset_counts: got %0d/%0d expected 0/0", cycle_count, stall_count); end
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("FAIL mid_drain_reset_pipe: got %b expected 0", pipe_ena); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_no_drain: got %0d expected 0", state); end
    @(negedge clk); rst = 1; dbg_cmd = 2'b10;
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL first_edge_after_reset: got %0d expected 2", state); end
    dbg_cmd = 2'b00;
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_rt_hazard();
    test_branch_priority();
    test_ena_freeze();
    test_stop();
    test_step();
    test_halt_drain();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
